// File: rtl/bcd_render_pkg.sv
// +----------------------------------------------------------------------+
// | bcd_render_pkg : shared codes, FSM states and colour for BCD HUD     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package bcd_render_pkg;

  localparam logic [3:0]  BCD_MINUS     = 4'hA;
  localparam logic [3:0]  BCD_BLANK     = 4'hC;
  localparam logic [11:0] BCD_COLOR_DEF = 12'h5FF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/digit_glyph_rom.sv
// +----------------------------------------------------------------------+
// | digit_glyph_rom : 8x8 glyphs for 0-9 and minus, row 0 = top         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module digit_glyph_rom (
  input  logic [3:0] digit,
  input  logic [2:0] row,
  output logic [7:0] bitmap_row
);

  logic [63:0] w_glyph;

  // Each glyph is packed top row first; bit 0 of every row is the spacing column.
  always_comb begin
    w_glyph = 64'h0;
    case (digit)
      4'h0:    w_glyph = 64'hFE82_8282_8282_82FE;
      4'h1:    w_glyph = 64'h1030_5010_1010_10FE;
      4'h2:    w_glyph = 64'hFE02_02FE_8080_80FE;
      4'h3:    w_glyph = 64'hFE02_02FE_0202_02FE;
      4'h4:    w_glyph = 64'h8282_82FE_0202_0202;
      4'h5:    w_glyph = 64'hFE80_80FE_0202_02FE;
      4'h6:    w_glyph = 64'hFE80_80FE_8282_82FE;
      4'h7:    w_glyph = 64'hFE02_0204_0810_1010;
      4'h8:    w_glyph = 64'hFE82_82FE_8282_82FE;
      4'h9:    w_glyph = 64'hFE82_82FE_0202_02FE;
      4'hA:    w_glyph = 64'h0000_007C_0000_0000;
      default: w_glyph = 64'h0;
    endcase
    bitmap_row = w_glyph[{3'd7 - row, 3'b000} +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/bcd_seq_render_engine.sv
// +----------------------------------------------------------------------+
// | bcd_seq_render_engine : signed binary -> BCD, rendered as HUD strip  |
// | Option macro: LEADING_ZERO_BLANK_EN                    Rev 1.0       |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_seq_render_engine
  import bcd_render_pkg::*;
#(
  parameter int                     SCREEN_WIDTH = 10,
  parameter int                     SEQ_LEN      = 20,
  parameter int                     NUM_DIGITS   = 6,
  parameter int                     PIXEL_WIDTH  = 12,
  parameter int                     FONT_WIDTH   = 8,
  parameter logic [PIXEL_WIDTH-1:0] BCD_COLOR    = PIXEL_WIDTH'(BCD_COLOR_DEF)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEQ_LEN-1:0]      in_value,
  output logic                    conv_done,
  output logic                    overflow,
  input  logic                    seq_on,
  input  logic [SCREEN_WIDTH-1:0] seq_x_rom,
  input  logic [SCREEN_WIDTH-1:0] seq_y_rom,
  input  logic [PIXEL_WIDTH-1:0]  background_rgb,
  output logic [PIXEL_WIDTH-1:0]  rgb
);

  localparam int CALC_DIGITS = (SEQ_LEN * 302 + 999) / 1000;
  localparam int BCD_DIGITS  = (CALC_DIGITS > NUM_DIGITS) ? CALC_DIGITS : NUM_DIGITS;
  localparam int BCD_W       = 4 * BCD_DIGITS;
  localparam int DISP_W      = 4 * NUM_DIGITS;
  localparam int SR_W        = BCD_W + SEQ_LEN;
  localparam int CNT_W       = $clog2(SEQ_LEN + 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SR_W-1:0]         sr_q, sr_d;
  logic                    conv_sign_q, conv_sign_d;
  logic                    disp_sign_q, disp_sign_d;
  logic [DISP_W-1:0]       disp_q, disp_d;
  logic                    overflow_q, overflow_d;
  logic                    conv_done_q, conv_done_d;
  logic [3:0]              code_q, code_d;
  logic [2:0]              px_q, px_d;
  logic [2:0]              row_q, row_d;
  logic                    on_q, on_d;
  logic [PIXEL_WIDTH-1:0]  bg_q, bg_d;
  logic [PIXEL_WIDTH-1:0]  rgb_q, rgb_d;

  logic [SEQ_LEN-1:0]      w_mag;
  logic [SR_W-1:0]         w_adj_sr;
  logic                    w_ovf;
  logic [SCREEN_WIDTH-1:0] w_col;
  logic [7:0]              w_glyph_row;
  logic                    w_unused;

  assign in_ready  = (state_q == IDLE);
  assign conv_done = conv_done_q;
  assign overflow  = overflow_q;
  assign rgb       = rgb_q;
  assign w_unused  = ^seq_y_rom[SCREEN_WIDTH-1:3];

  // Negating the most negative input wraps to 2^(SEQ_LEN-1), which is the correct unsigned magnitude.
  assign w_mag = in_value[SEQ_LEN-1] ? (~in_value + 1'b1) : in_value;

  generate
    if (BCD_DIGITS > NUM_DIGITS) begin : g_ovf_hi
      assign w_ovf = |sr_q[SEQ_LEN+DISP_W +: BCD_W-DISP_W];
    end else begin : g_ovf_none
      assign w_ovf = 1'b0;
    end
  endgenerate

  always_comb begin
    w_adj_sr = sr_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (sr_q[SEQ_LEN+4*i +: 4] >= 4'd5) w_adj_sr[SEQ_LEN+4*i +: 4] = sr_q[SEQ_LEN+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    conv_sign_d = conv_sign_q;
    disp_sign_d = disp_sign_q;
    disp_d      = disp_q;
    overflow_d  = overflow_q;
    conv_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          conv_sign_d = in_value[SEQ_LEN-1];
          sr_d        = {{BCD_W{1'b0}}, w_mag};
          cnt_d       = '0;
          state_d     = CONV;
        end
      end
      CONV: begin
        sr_d  = {w_adj_sr[SR_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SEQ_LEN - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        disp_sign_d = conv_sign_q;
        overflow_d  = w_ovf;
        disp_d      = w_ovf ? {NUM_DIGITS{4'd9}} : sr_q[SEQ_LEN +: DISP_W];
        conv_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // w_lz[i]: digit i and every digit above it are zero, so digit i is a leading zero.
  logic [NUM_DIGITS-1:0] w_lz;
  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
      if (g == 0) begin : g_lsd
        assign w_lz[g] = 1'b0;
      end else begin : g_upper
        assign w_lz[g] = (disp_q[DISP_W-1:4*g] == '0);
      end
    end
  endgenerate
`endif

  always_comb begin
    w_col  = seq_x_rom / SCREEN_WIDTH'(FONT_WIDTH);
    px_d   = 3'(seq_x_rom % SCREEN_WIDTH'(FONT_WIDTH));
    row_d  = seq_y_rom[2:0];
    on_d   = seq_on;
    bg_d   = background_rgb;
    code_d = BCD_BLANK;
    if (w_col == '0) code_d = disp_sign_q ? BCD_MINUS : BCD_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_col == SCREEN_WIDTH'(NUM_DIGITS - i)) begin
        code_d = disp_q[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (w_lz[i]) code_d = BCD_BLANK;
`endif
      end
    end
    rgb_d = (on_q && w_glyph_row[3'(FONT_WIDTH-1) - px_q]) ? BCD_COLOR : bg_q;
  end

  digit_glyph_rom u_glyph_rom (
    .digit      (code_q),
    .row        (row_q),
    .bitmap_row (w_glyph_row)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      conv_sign_q <= 1'b0;
      disp_sign_q <= 1'b0;
      disp_q      <= '0;
      overflow_q  <= 1'b0;
      conv_done_q <= 1'b0;
      code_q      <= BCD_BLANK;
      px_q        <= '0;
      row_q       <= '0;
      on_q        <= 1'b0;
      bg_q        <= '0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      conv_sign_q <= conv_sign_d;
      disp_sign_q <= disp_sign_d;
      disp_q      <= disp_d;
      overflow_q  <= overflow_d;
      conv_done_q <= conv_done_d;
      code_q      <= code_d;
      px_q        <= px_d;
      row_q       <= row_d;
      on_q        <= on_d;
      bg_q        <= bg_d;
      rgb_q       <= rgb_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_seq_render_engine.sv
// +----------------------------------------------------------------------+
// | tb_bcd_seq_render_engine : scoreboard bench, 6-digit and 4-digit DUT |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bcd_seq_render_engine;

  localparam logic [11:0] COLOR = 12'h5FF;
  localparam logic [11:0] BG    = 12'h0A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [19:0] in_value = '0;
  logic        seq_on = 1'b0;
  logic [9:0]  seq_x_rom = '0;
  logic [9:0]  seq_y_rom = '0;
  logic [11:0] background_rgb = BG;
  logic        in_ready, conv_done, overflow;
  logic        in_ready4, conv_done4, overflow4;
  logic [11:0] rgb, rgb4;

  typedef struct { logic [11:0] e; logic [11:0] e4; int x; int y; } pix_t;
  typedef struct { bit ovf; bit ovf4; int acc; } conv_t;
  pix_t pq[$];
  conv_t cq[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic pvalid = 1'b0;
  logic [1:0] pv;

  logic [7:0] font_r0 [10] = '{8'hFE, 8'h10, 8'hFE, 8'hFE, 8'h82, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE};
  logic [7:0] font_r1 [10] = '{8'h82, 8'h30, 8'h02, 8'h02, 8'h82, 8'h80, 8'h80, 8'h02, 8'h82, 8'h82};
  logic [7:0] font_r3 [10] = '{8'h82, 8'h10, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'h04, 8'hFE, 8'hFE};
  logic [7:0] font_r4 [10] = '{8'h82, 8'h10, 8'h80, 8'h02, 8'h02, 8'h02, 8'h82, 8'h08, 8'h82, 8'h02};

  bcd_seq_render_engine u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .conv_done(conv_done), .overflow(overflow), .seq_on(seq_on), .seq_x_rom(seq_x_rom),
    .seq_y_rom(seq_y_rom), .background_rgb(background_rgb), .rgb(rgb)
  );

  bcd_seq_render_engine #(.NUM_DIGITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_value(in_value),
    .conv_done(conv_done4), .overflow(overflow4), .seq_on(seq_on), .seq_x_rom(seq_x_rom),
    .seq_y_rom(seq_y_rom), .background_rgb(background_rgb), .rgb(rgb4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or posedge rst) begin
    if (rst) pv <= 2'b00;
    else     pv <= {pv[0], pvalid};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] font_row(input byte ch, input int r);
    int d;
    if (ch == "-") return (r == 3) ? 8'h7C : 8'h00;
    if (ch < "0" || ch > "9") return 8'h00;
    d = int'(ch - "0");
    case (r)
      0:       return font_r0[d];
      1:       return font_r1[d];
      3:       return font_r3[d];
      default: return font_r4[d];
    endcase
  endfunction

  function automatic logic [11:0] exp_px(input string s, input int x, input int r);
    byte        ch;
    logic [7:0] b;
    ch = (x / 8 < s.len()) ? s[x / 8] : 8'h20;
    b  = font_row(ch, r);
    return b[7 - (x % 8)] ? COLOR : BG;
  endfunction

  task automatic probe(input int x, input int y, input logic on, input logic [11:0] bg,
                       input logic [11:0] e, input logic [11:0] e4);
    @(negedge clk);
    seq_on = on; seq_x_rom = 10'(x); seq_y_rom = 10'(y); background_rgb = bg;
    pvalid = 1'b1;
    pq.push_back('{e, e4, x, y});
  endtask

  task automatic drain();
    @(negedge clk);
    pvalid = 1'b0; seq_on = 1'b0; background_rgb = BG;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_strip(input string s, input string s4);
    int rows[4] = '{0, 1, 3, 4};
    foreach (rows[k])
      for (int x = 0; x < 64; x++)
        probe(x, rows[k], 1'b1, BG, exp_px(s, x, rows[k]), exp_px(s4, x, rows[k]));
    drain();
  endtask

  task automatic send(input logic [19:0] v, input bit ovf, input bit ovf4);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_value = v;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin checks++; errors++; $display("FAIL accept timeout: in_ready 0 want 1"); end
    @(posedge clk); #1;
    cq.push_back('{ovf, ovf4, cyc});
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!in_ready && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) begin checks++; errors++; $display("FAIL idle timeout: in_ready 0 want 1"); end
  endtask

  always @(negedge clk) begin
    pix_t  p;
    conv_t c;
    if (!rst) begin
      if (pv[1]) begin
        if (pq.size() == 0) begin
          checks++; errors++; $display("FAIL rgb: output with no expected entry");
        end else begin
          p = pq.pop_front();
          chk($sformatf("rgb x=%0d y=%0d", p.x, p.y), 32'(rgb), 32'(p.e));
          chk($sformatf("rgb4 x=%0d y=%0d", p.x, p.y), 32'(rgb4), 32'(p.e4));
        end
      end
      if (conv_done || conv_done4) begin
        if (cq.size() == 0) begin
          checks++; errors++;
          $display("FAIL conv_done: got pulse %0b/%0b want none", conv_done, conv_done4);
        end else begin
          c = cq.pop_front();
          chk("conv_done", 32'(conv_done), 32'd1);
          chk("conv_done4", 32'(conv_done4), 32'd1);
          chk("overflow", 32'(overflow), 32'(c.ovf));
          chk("overflow4", 32'(overflow4), 32'(c.ovf4));
          chk("commit latency", 32'(cyc - c.acc), 32'd21);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset rgb", 32'(rgb), 32'd0);
    chk("reset conv_done", 32'(conv_done), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Reset state, then reset while the pixel pipe is busy
    check_strip(" 000000", " 0000");
    for (int x = 0; x < 4; x++) probe(x, 0, 1'b1, BG, BG, BG);
    #2 rst = 1'b1; pvalid = 1'b0; pq.delete();
    #1 chk("midframe rgb", 32'(rgb), 32'd0);
    chk("midframe in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst = 1'b0;

    // 12345: busy window, digits, last row of the '5'
    send(20'd12345, 1'b0, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    wait_idle(n);
    chk("busy cycles", 32'(n), 32'd21);
    repeat (2) @(negedge clk);
    check_strip(" 012345", " 9999");
    for (int x = 48; x < 56; x++) probe(x, 7, 1'b1, BG, (x < 55) ? COLOR : BG, BG);
    drain();
    chk("overflow4 hold", 32'(overflow4), 32'd1);

    // -1
    send(20'hFFFFF, 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    wait_idle(n);
    repeat (2) @(negedge clk);
    check_strip("-000001", "-0001");

    // Most negative value
    send(20'h80000, 1'b0, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    wait_idle(n);
    repeat (2) @(negedge clk);
    check_strip("-524288", "-9999");
    chk("overflow -2^19", 32'(overflow), 32'd0);

    // 777 held on in_valid while 12345 converts
    send(20'd12345, 1'b0, 1'b1);
    @(negedge clk); in_value = 20'd777;
    send(20'd777, 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    wait_idle(n);
    repeat (2) @(negedge clk);
    check_strip(" 000777", " 0777");

    // Reset in the middle of a conversion
    send(20'd12345, 1'b0, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1; cq.delete(); pq.delete();
    #1 chk("conv reset in_ready", 32'(in_ready), 32'd1);
    chk("conv reset conv_done", 32'(conv_done), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post reset in_ready", 32'(in_ready), 32'd1);
    check_strip(" 000000", " 0000");
    probe(20, 3, 1'b0, 12'h123, 12'h123, 12'h123);
    drain();

    chk("conv queue empty", 32'(cq.size()), 32'd0);
    chk("pixel queue empty", 32'(pq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
